// File: rtl/pll_reset_seq_pkg.sv
// Shared state encodings and helpers for the PLL reset sequencer.
package pll_reset_seq_pkg;

  // Encodings are also used by debug/status readout.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_ff.sv
// Generic multi-flop bit synchronizer with synchronous clear.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("sync_ff: STAGES must be at least 2");
    end
  endgenerate

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Reset sequencer: qualifies PLL lock, holds reset, re-asserts on loss or software request.
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 4800,
  parameter int unsigned RST_HOLD_CYCLES    = 48,
  parameter int unsigned LOSS_CNT_W         = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  locked_in,
  input  logic                  sw_reset_req,
  output logic                  reset_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int unsigned CNT_W = $clog2(max_u(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES) + 1);

  generate
    if (LOCK_STABLE_CYCLES == 0 || RST_HOLD_CYCLES == 0 || LOSS_CNT_W == 0 || SYNC_STAGES < 2)
    begin : g_bad_params
      $error("pll_reset_seq: illegal parameter value");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock_s;
  logic             loss_c;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked_in),
    .q     (lock_s)
  );

  // State, shared counter, next-state-decoded outputs and saturating loss counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_WAIT_LOCK;
      cnt             <= '0;
      reset_out       <= 1'b1;
      ready           <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      reset_out <= (state_nxt != ST_RUN);
      ready     <= (state_nxt == ST_RUN);
      if (loss_c && (lock_loss_count != {LOSS_CNT_W{1'b1}}))
        lock_loss_count <= lock_loss_count + LOSS_CNT_W'(1);
    end
  end

  // The high sample that leaves WAIT_LOCK is the first of the stable window,
  // so STABLE leaves once it has seen the last required sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_c    = 1'b0;
    case (state)
      ST_WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_W'(RST_HOLD_CYCLES)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
          loss_c    = 1'b1;
        end else if (sw_reset_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
